cnv_row_acc: RTL and testbench

- Parametrised row-accumulation stage for the convolution PE. Successor of the fixed 3-tap, always-accumulate row unit.
- Sums K per-tap MAC results each beat and either adds them to a partial sum read from the psum buffer or starts a fresh sum.
- On the last input-channel pass it optionally applies ReLU, shift and saturation before writeback.
- Sits between the MAC array and the psum SRAM. Output uses a valid/ready handshake; the row is sequenced by a small FSM.

---
 rtl/cnv_row_acc.sv | 174 +++++++++++++++++
 tb/tb_cnv_row_acc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnv_row_acc.sv
// Row-accumulation stage: sums K MAC taps per beat, adds the stored partial sum,
// and optionally applies ReLU/shift/clamp on the final pass before writeback.
module cnv_row_acc #(
    parameter int K       = 3,
    parameter int MAC_W   = 20,
    parameter int PSUM_W  = 24,
    parameter int ROW_LEN = 16,
    parameter int OUT_W   = 8,
    localparam int AW     = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cnv_sta,
    input  logic                 cnv_abt,
    input  logic                 cfg_first,
    input  logic                 cfg_last,
    input  logic [4:0]           cfg_shift,
    input  logic [AW:0]          cfg_len,
    input  logic                 mac_vld,
    output logic                 mac_rdy,
    input  logic [K*MAC_W-1:0]   mac_dat,
    output logic                 psum_rd_en,
    output logic [AW-1:0]        psum_rd_addr,
    input  logic [PSUM_W-1:0]    psum_rd_dat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [AW-1:0]        out_addr,
    output logic [PSUM_W-1:0]    out_dat,
    output logic                 row_done,
    output logic                 busy,
    output logic                 sat_flg
);

    localparam int TS_W = MAC_W + $clog2(K);
    localparam logic [AW:0]       LEN_MAX  = (AW+1)'(ROW_LEN);
    localparam logic [PSUM_W-1:0] PSUM_POS = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic [PSUM_W-1:0] PSUM_NEG = {1'b1, {(PSUM_W-1){1'b0}}};
    localparam logic [PSUM_W-1:0] ACT_MAX  = PSUM_W'((64'd1 << OUT_W) - 64'd1);

    generate
        if (TS_W > PSUM_W) begin : g_width_check
            $error("cnv_row_acc: tap-sum width exceeds PSUM_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic                first_r, last_r;
    logic [4:0]          shift_r;
    logic [AW:0]         len_r, cnt, cnt_inc, len_eff;
    logic                s1_vld, s2_vld, rd_pend;
    logic [PSUM_W-1:0]   s1_tap, s1_psum, s2_dat;
    logic [AW-1:0]       s1_addr, s2_addr;
    logic                s1_adv, accept, start;
    logic signed [TS_W-1:0] tap_sum;
    logic [PSUM_W-1:0]   psum_use, acc_sat, relu, shifted, act, res;
    logic [PSUM_W:0]     acc;
    logic                ovf;

    assign s1_adv       = ~s2_vld | out_rdy;
    assign mac_rdy      = (state == RUN) & (~s1_vld | s1_adv);
    assign accept       = mac_vld & mac_rdy;
    assign start        = (state == IDLE) & cnv_sta & ~cnv_abt;
    assign cnt_inc      = cnt + {{AW{1'b0}}, 1'b1};
    assign len_eff      = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    assign psum_rd_en   = accept & ~first_r;
    assign psum_rd_addr = cnt[AW-1:0];
    assign busy         = (state != IDLE);
    assign out_vld      = s2_vld;
    assign out_addr     = s2_addr;
    assign out_dat      = s2_dat;

    always_comb begin
        state_nxt = state;
        row_done  = 1'b0;
        case (state)
            IDLE:    if (cnv_sta) state_nxt = RUN;
            RUN:     if (accept && cnt_inc == len_r) state_nxt = DRAIN;
            DRAIN: begin
                if (!s1_vld && !s2_vld) begin
                    row_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (cnv_abt) begin
            state_nxt = IDLE;
            row_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        tap_sum = '0;
        for (int i = 0; i < K; i++) begin
            tap_sum = tap_sum + TS_W'($signed(mac_dat[i*MAC_W +: MAC_W]));
        end
    end

    // Read data is only on the bus the cycle after the read; afterwards use the captured copy.
    always_comb begin
        psum_use = first_r ? '0 : (rd_pend ? psum_rd_dat : s1_psum);
        acc      = {s1_tap[PSUM_W-1], s1_tap} + {psum_use[PSUM_W-1], psum_use};
        ovf      = acc[PSUM_W] != acc[PSUM_W-1];
        acc_sat  = ovf ? (acc[PSUM_W] ? PSUM_NEG : PSUM_POS) : acc[PSUM_W-1:0];
        relu     = acc_sat[PSUM_W-1] ? '0 : acc_sat;
        shifted  = relu >> shift_r;
        act      = (shifted > ACT_MAX) ? ACT_MAX : shifted;
        res      = last_r ? act : acc_sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_r <= 1'b0;
            last_r  <= 1'b0;
            shift_r <= '0;
            len_r   <= '0;
            cnt     <= '0;
        end else if (start) begin
            first_r <= cfg_first;
            last_r  <= cfg_last;
            shift_r <= cfg_shift;
            len_r   <= len_eff;
            cnt     <= '0;
        end else if (accept) begin
            cnt     <= cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_tap  <= '0;
            s1_addr <= '0;
            s1_psum <= '0;
            rd_pend <= 1'b0;
            s2_vld  <= 1'b0;
            s2_addr <= '0;
            s2_dat  <= '0;
            sat_flg <= 1'b0;
        end else begin
            rd_pend <= psum_rd_en & ~cnv_abt;
            if (rd_pend) s1_psum <= psum_rd_dat;
            if (start) sat_flg <= 1'b0;
            if (cnv_abt) begin
                s1_vld <= 1'b0;
                s2_vld <= 1'b0;
            end else begin
                if (accept) begin
                    s1_vld  <= 1'b1;
                    s1_tap  <= PSUM_W'(tap_sum);
                    s1_addr <= cnt[AW-1:0];
                end else if (s1_adv) begin
                    s1_vld  <= 1'b0;
                end
                if (s1_adv) begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_addr <= s1_addr;
                        s2_dat  <= res;
                        if (ovf) sat_flg <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cnv_row_acc.sv
// Scoreboard bench for cnv_row_acc: expected pixels are queued at each accepted
// beat and checked in order as results are handed downstream.
module tb_cnv_row_acc;

    localparam int K = 3, MAC_W = 20, PSUM_W = 24, ROW_LEN = 16, OUT_W = 8;
    localparam int AW = $clog2(ROW_LEN);
    localparam longint PMAX = (longint'(1) << (PSUM_W-1)) - 1;
    localparam longint PMIN = -PMAX - 1;
    localparam longint AMAX = (longint'(1) << OUT_W) - 1;

    logic clk = 0, rst_n = 0;
    logic cnv_sta = 0, cnv_abt = 0, cfg_first = 0, cfg_last = 0;
    logic [4:0] cfg_shift = '0;
    logic [AW:0] cfg_len = '0;
    logic mac_vld = 0, mac_rdy;
    logic [K*MAC_W-1:0] mac_dat = '0;
    logic psum_rd_en;
    logic [AW-1:0] psum_rd_addr;
    logic [PSUM_W-1:0] psum_rd_dat = '0;
    logic out_vld, out_rdy = 1;
    logic [AW-1:0] out_addr;
    logic [PSUM_W-1:0] out_dat;
    logic row_done, busy, sat_flg;

    cnv_row_acc #(.K(K), .MAC_W(MAC_W), .PSUM_W(PSUM_W), .ROW_LEN(ROW_LEN), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cnv_sta(cnv_sta), .cnv_abt(cnv_abt),
        .cfg_first(cfg_first), .cfg_last(cfg_last), .cfg_shift(cfg_shift), .cfg_len(cfg_len),
        .mac_vld(mac_vld), .mac_rdy(mac_rdy), .mac_dat(mac_dat),
        .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr), .psum_rd_dat(psum_rd_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_addr(out_addr), .out_dat(out_dat),
        .row_done(row_done), .busy(busy), .sat_flg(sat_flg)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; longint dat; int cyc; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic signed [PSUM_W-1:0] mem [ROW_LEN];
    int tap_tbl [ROW_LEN][K];
    int total = 0, bad = 0;
    int cyc = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, stall_cnt = 0;
    int rdy_mode = 0;
    bit lat_chk = 0, hold_prev = 0;
    logic [AW-1:0] prev_addr;
    logic [PSUM_W-1:0] prev_dat;

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [K*MAC_W-1:0] packTaps(input int i);
        logic [K*MAC_W-1:0] v;
        v = '0;
        for (int k = 0; k < K; k++) v[k*MAC_W +: MAC_W] = MAC_W'(tap_tbl[i][k]);
        return v;
    endfunction

    function automatic longint model(input bit first, input bit last, input int sh, input int i);
        longint s = 0;
        for (int k = 0; k < K; k++) s += longint'(tap_tbl[i][k]);
        if (!first) s += longint'(mem[i]);
        if (s > PMAX) s = PMAX;
        else if (s < PMIN) s = PMIN;
        if (last) begin
            if (s < 0) s = 0;
            s = s >> sh;
            if (s > AMAX) s = AMAX;
        end
        return s;
    endfunction

    // Buffer model with 1-cycle read latency; garbage when idle so stale data is noticed.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (psum_rd_en) psum_rd_dat <= mem[psum_rd_addr];
        else            psum_rd_dat <= PSUM_W'($urandom);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_rdy = 1;
            else if ((cyc % 8) < 4) out_rdy = ((cyc % 4) == 0 || (cyc % 4) == 3);
            else out_rdy = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (psum_rd_en) rd_cnt++;
            if (row_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (hold_prev) begin
                checkOutput("hold_vld", out_vld, 1);
                checkOutput("hold_addr", out_addr, prev_addr);
                checkOutput("hold_dat", out_dat, prev_dat);
            end
            hold_prev = out_vld & ~out_rdy & ~cnv_abt;
            prev_addr = out_addr;
            prev_dat  = out_dat;
            if (out_vld && out_rdy && !cnv_abt) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out", out_addr, -1);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("out_addr", out_addr, mon_e.addr);
                    checkOutput("out_dat", longint'($signed(out_dat)), mon_e.dat);
                    if (lat_chk) checkOutput("latency", cyc - mon_e.cyc, 2);
                end
                last_hs_cyc = cyc;
            end
        end
    end

    task automatic applyStimulus(input bit first, input bit last, input int sh,
                                 input int len_cfg, input int nbeats);
        int guard;
        cfg_first = first;
        cfg_last  = last;
        cfg_shift = 5'(sh);
        cfg_len   = (AW+1)'(len_cfg);
        cnv_sta   = 1;
        @(posedge clk);
        #1;
        cnv_sta = 0;
        for (int i = 0; i < nbeats; i++) begin
            mac_vld = 1;
            mac_dat = packTaps(i);
            guard = 0;
            @(negedge clk);
            while (!mac_rdy && guard < 200) begin
                stall_cnt++;
                @(negedge clk);
                guard++;
            end
            if (!mac_rdy) begin
                checkOutput("accept_timeout", 0, 1);
                break;
            end
            if (!first) begin
                checkOutput("rd_en", psum_rd_en, 1);
                checkOutput("rd_addr", psum_rd_addr, i);
            end else begin
                checkOutput("rd_en_first", psum_rd_en, 0);
            end
            sb.push_back('{i, model(first, last, sh, i), cyc});
            @(posedge clk);
            #1;
        end
        mac_vld = 0;
    endtask

    task automatic waitDrain(input string tag);
        int guard = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, "_drain"}, longint'(sb.size() == 0 && !busy), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        for (int i = 0; i < ROW_LEN; i++) mem[i] = PSUM_W'(100 * i);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_vld", out_vld, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mac_rdy", mac_rdy, 0);
        checkOutput("rst_row_done", row_done, 0);
        checkOutput("rst_sat", sat_flg, 0);
        checkOutput("rst_out_dat", out_dat, 0);
        rst_n = 1;
        @(posedge clk);
        #1;

        $display("[TB] case 1: fresh sum, len 4");
        for (int i = 0; i < ROW_LEN; i++) begin
            tap_tbl[i][0] = 1; tap_tbl[i][1] = 2; tap_tbl[i][2] = 3;
        end
        rd_cnt = 0; d0 = done_cnt; lat_chk = 1;
        applyStimulus(1, 0, 0, 4, 4);
        waitDrain("c1");
        checkOutput("c1_rd_cnt", rd_cnt, 0);
        checkOutput("c1_row_done_cnt", done_cnt - d0, 1);
        checkOutput("c1_row_done_cyc", done_cyc, last_hs_cyc + 1);

        $display("[TB] case 2: accumulate, len 16 (encoded 0)");
        for (int i = 0; i < ROW_LEN; i++) begin
            tap_tbl[i][0] = -5 + i; tap_tbl[i][1] = i; tap_tbl[i][2] = 5 + i;
        end
        d0 = done_cnt;
        applyStimulus(0, 0, 0, 0, 16);
        waitDrain("c2");
        checkOutput("c2_row_done_cnt", done_cnt - d0, 1);

        $display("[TB] case 3: accumulate with backpressure");
        lat_chk = 0; rdy_mode = 1; stall_cnt = 0;
        applyStimulus(0, 0, 0, 16, 16);
        waitDrain("c3");
        checkOutput("c3_stall_seen", longint'(stall_cnt > 0), 1);
        rdy_mode = 0;
        @(posedge clk);
        #1;

        $display("[TB] case 4: saturation");
        lat_chk = 1;
        mem[0] = 24'sh7FFFF0;
        tap_tbl[0][0] = 16; tap_tbl[0][1] = 16; tap_tbl[0][2] = 0;
        applyStimulus(0, 0, 0, 1, 1);
        waitDrain("c4");
        checkOutput("c4_sat_flg", sat_flg, 1);

        $display("[TB] case 5: final pass relu/shift/clamp");
        tap_tbl[0][0] = -40;  tap_tbl[0][1] = 0; tap_tbl[0][2] = 0;
        tap_tbl[1][0] = 1000; tap_tbl[1][1] = 0; tap_tbl[1][2] = 0;
        tap_tbl[2][0] = 2000; tap_tbl[2][1] = 0; tap_tbl[2][2] = 0;
        cfg_first = 1; cfg_last = 1; cfg_shift = 5'd2; cfg_len = (AW+1)'(3); cnv_sta = 1;
        @(posedge clk);
        #1;
        checkOutput("c5_sat_cleared", sat_flg, 0);
        cnv_sta = 0;
        @(posedge clk);
        #1;
        checkOutput("c5_busy", busy, 1);
        cnv_abt = 1;
        @(posedge clk);
        #1;
        cnv_abt = 0;
        applyStimulus(1, 1, 2, 3, 3);
        waitDrain("c5");

        $display("[TB] case 6: abort mid-row then restart");
        for (int i = 0; i < ROW_LEN; i++) begin
            tap_tbl[i][0] = -5 + i; tap_tbl[i][1] = i; tap_tbl[i][2] = 5 + i;
        end
        d0 = done_cnt;
        applyStimulus(1, 0, 0, 16, 5);
        checkOutput("c6_pre_vld", out_vld, 1);
        cnv_abt = 1;
        @(posedge clk);
        #1;
        cnv_abt = 0;
        sb.delete();
        @(negedge clk);
        checkOutput("c6_out_vld", out_vld, 0);
        checkOutput("c6_busy", busy, 0);
        repeat (3) @(negedge clk);
        checkOutput("c6_no_row_done", done_cnt - d0, 0);
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 2, 2);
        waitDrain("c6");
        checkOutput("c6_row_done", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
